// File: rtl/led_channel_writer.sv
// Parses 2-byte (header, data) frames and loads one LED channel per frame; outputs registered, strobe 1 cycle after data accept.
// in_ready drops only during the one-cycle issue state; a stalled byte is held by the source.
module led_channel_writer #(
   parameter logic [3:0] SYNC_NIBBLE    = 4'hA,
   parameter int         TIMEOUT_CYCLES = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] Channel_1_data,
   output logic [7:0] Channel_2_data,
   output logic       Channel_1_enable,
   output logic       Channel_2_enable,
   output logic       selector,
   output logic       frame_error,
   output logic       busy
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef struct packed {
      logic [3:0] sync;
      logic [1:0] rsvd;
      logic       sel;
      logic       ch;
   } hdr_t;

   typedef enum logic [1:0] {S_HEADER, S_DATA, S_ISSUE} state_t;

   state_t        state, state_nxt;
   hdr_t          hdr_in;
   logic          hdr_sel_q, hdr_ch_q;
   logic [CW-1:0] idle_cnt, idle_cnt_nxt;
   logic          xfer, hdr_ok, timeout;

   logic [7:0]    ch1_nxt, ch2_nxt;
   logic          en1_nxt, en2_nxt, sel_nxt, err_nxt, rdy_nxt, busy_nxt;

   assign hdr_in  = hdr_t'(in_data);
   assign xfer    = in_valid & in_ready;
   assign hdr_ok  = (hdr_in.sync == SYNC_NIBBLE) && (hdr_in.rsvd == 2'b00);
   // Limit is checked on the registered count, so a byte arriving that same cycle still wins.
   assign timeout = (state == S_DATA) && !xfer && (idle_cnt == CW'(TIMEOUT_CYCLES));

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_HEADER;
         idle_cnt  <= '0;
         hdr_sel_q <= 1'b0;
         hdr_ch_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         idle_cnt <= idle_cnt_nxt;
         if (state == S_HEADER && xfer && hdr_ok) begin
            hdr_sel_q <= hdr_in.sel;
            hdr_ch_q  <= hdr_in.ch;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      idle_cnt_nxt = '0;
      case (state)
         S_HEADER: if (xfer && hdr_ok) state_nxt = S_DATA;
         S_DATA: begin
            if (xfer) begin
               state_nxt = S_ISSUE;
            end else if (timeout) begin
               state_nxt = S_HEADER;
            end else begin
               idle_cnt_nxt = idle_cnt + CW'(1);
            end
         end
         S_ISSUE: state_nxt = S_HEADER;
         default: state_nxt = S_HEADER;
      endcase
   end

   always_comb begin
      ch1_nxt  = Channel_1_data;
      ch2_nxt  = Channel_2_data;
      sel_nxt  = selector;
      en1_nxt  = 1'b0;
      en2_nxt  = 1'b0;
      err_nxt  = timeout || (state == S_HEADER && xfer && !hdr_ok);
      rdy_nxt  = (state_nxt != S_ISSUE);
      busy_nxt = (state_nxt != S_HEADER);
      if (state == S_DATA && xfer) begin
         sel_nxt = hdr_sel_q;
         if (hdr_ch_q) begin
            ch2_nxt = in_data;
            en2_nxt = 1'b1;
         end else begin
            ch1_nxt = in_data;
            en1_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         Channel_1_data   <= 8'h00;
         Channel_2_data   <= 8'h00;
         Channel_1_enable <= 1'b0;
         Channel_2_enable <= 1'b0;
         selector         <= 1'b0;
         frame_error      <= 1'b0;
         in_ready         <= 1'b1;
         busy             <= 1'b0;
      end else begin
         Channel_1_data   <= ch1_nxt;
         Channel_2_data   <= ch2_nxt;
         Channel_1_enable <= en1_nxt;
         Channel_2_enable <= en2_nxt;
         selector         <= sel_nxt;
         frame_error      <= err_nxt;
         in_ready         <= rdy_nxt;
         busy             <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_led_channel_writer.sv
// Directed bench for led_channel_writer with a write/error scoreboard checked at the falling edge.
module tb_led_channel_writer;
   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] Channel_1_data, Channel_2_data;
   logic       Channel_1_enable, Channel_2_enable;
   logic       selector, frame_error, busy;

   typedef struct {
      logic       ch;
      logic       sel;
      logic [7:0] dat;
   } wr_t;

   wr_t  exp_q[$];
   int   err_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic [7:0] m_ch1, m_ch2;
   logic       m_sel;

   led_channel_writer dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .Channel_1_data(Channel_1_data), .Channel_2_data(Channel_2_data),
      .Channel_1_enable(Channel_1_enable), .Channel_2_enable(Channel_2_enable),
      .selector(selector), .frame_error(frame_error), .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called just after a rising edge; returns just after the edge that took the byte.
   task automatic send(input logic [7:0] b, input bit keep);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 8) begin
         @(posedge clock); #1;
         n++;
      end
      chk("ready_wait", int'(n < 8), 1);
      @(posedge clock); #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic frame(input logic [7:0] hdr, input logic [7:0] dat, input bit keep);
      wr_t w;
      w.ch  = hdr[0];
      w.sel = hdr[1];
      w.dat = dat;
      exp_q.push_back(w);
      send(hdr, 1'b1);
      send(dat, keep);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin : mon
      wr_t e;
      if (reset) begin
         m_ch1 <= 8'h00;
         m_ch2 <= 8'h00;
         m_sel <= 1'b0;
      end else begin
         chk("en_exclusive", int'(Channel_1_enable & Channel_2_enable), 0);
         if (Channel_1_enable | Channel_2_enable) begin
            chk("unexpected_enable", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("enable_target", int'({Channel_2_enable, Channel_1_enable}), e.ch ? 2 : 1);
               chk("ch1_data", int'(Channel_1_data), int'(e.ch ? m_ch1 : e.dat));
               chk("ch2_data", int'(Channel_2_data), int'(e.ch ? e.dat : m_ch2));
               chk("selector", int'(selector), int'(e.sel));
               if (e.ch) m_ch2 <= e.dat;
               else      m_ch1 <= e.dat;
               m_sel <= e.sel;
            end
         end else begin
            chk("ch1_hold", int'(Channel_1_data), int'(m_ch1));
            chk("ch2_hold", int'(Channel_2_data), int'(m_ch2));
            chk("sel_hold", int'(selector), int'(m_sel));
         end
         if (frame_error) begin
            chk("unexpected_error", int'(err_q.size() > 0), 1);
            if (err_q.size() > 0) void'(err_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ch1", int'(Channel_1_data), 0);
      chk("rst_ch2", int'(Channel_2_data), 0);
      chk("rst_en", int'({Channel_1_enable, Channel_2_enable}), 0);
      chk("rst_sel_err", int'({selector, frame_error}), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(in_ready), 1);
      reset = 1'b0;
      idle(2);

      // Channel 1 write, then channel 2 write with selector set.
      frame(8'hA0, 8'h5C, 1'b0);
      chk("issue_ready_low", int'(in_ready), 0);
      chk("issue_busy", int'(busy), 1);
      idle(1);
      chk("post_issue_ready", int'(in_ready), 1);
      chk("post_issue_busy", int'(busy), 0);
      frame(8'hA3, 8'hC3, 1'b0);
      idle(3);

      // Back-to-back frames with in_valid held high; data bytes may look like headers.
      send(8'hA1, 1'b1);
      t0 = cyc;
      begin
         wr_t w;
         w.ch = 1'b1; w.sel = 1'b0; w.dat = 8'hA5;
         exp_q.push_back(w);
      end
      send(8'hA5, 1'b1);
      frame(8'hA2, 8'h00, 1'b1);
      frame(8'hA3, 8'hFF, 1'b1);
      frame(8'hA0, 8'h12, 1'b0);
      chk("b2b_cycles", cyc - t0, 10);
      idle(3);

      // Bad headers: wrong sync nibble, then nonzero reserved bits.
      err_q.push_back(1);
      send(8'h51, 1'b0);
      chk("bad_hdr1_busy", int'(busy), 0);
      chk("bad_hdr1_err", int'(frame_error), 1);
      err_q.push_back(2);
      send(8'hA5, 1'b0);
      chk("bad_hdr2_busy", int'(busy), 0);
      idle(2);
      frame(8'hA0, 8'hFF, 1'b0);
      idle(3);

      // Timeout: 16 idle cycles still waiting, next cycle aborts.
      send(8'hA0, 1'b0);
      idle(16);
      chk("to_busy_before", int'(busy), 1);
      chk("to_err_before", int'(frame_error), 0);
      err_q.push_back(3);
      idle(1);
      chk("to_busy_after", int'(busy), 0);
      chk("to_err_pulse", int'(frame_error), 1);
      idle(4);
      err_q.push_back(4);
      send(8'h77, 1'b0);
      chk("hdr77_busy", int'(busy), 0);
      idle(3);

      // Data arriving on the cycle the counter reaches the limit is accepted.
      send(8'hA0, 1'b0);
      idle(16);
      begin
         wr_t w;
         w.ch = 1'b0; w.sel = 1'b0; w.dat = 8'h3C;
         exp_q.push_back(w);
      end
      send(8'h3C, 1'b0);
      chk("limit_data_busy", int'(busy), 1);
      idle(3);

      // Reset mid-frame discards the partial frame silently and clears held data.
      send(8'hA3, 1'b0);
      chk("midframe_busy", int'(busy), 1);
      reset = 1'b1;
      idle(2);
      chk("mf_rst_ch1", int'(Channel_1_data), 0);
      chk("mf_rst_ch2", int'(Channel_2_data), 0);
      chk("mf_rst_flags", int'({Channel_1_enable, Channel_2_enable, selector, frame_error, busy}), 0);
      reset = 1'b0;
      idle(24);
      chk("mf_no_timeout_busy", int'(busy), 0);

      chk("writes_drained", exp_q.size(), 0);
      chk("errors_drained", err_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
